// File: rtl/axi4_vip_arb_pkg.sv
// Shared types and helpers for the VIP slave channel arbiters.
//   arb_state_e : burst arbiter state (IDLE / LOCKED)
//   axi_resp_e  : AXI RRESP/BRESP encodings
//   clog2_min1  : index width that never collapses to 0 bits
package axi4_vip_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  // An index into a 1- or 2-entry table still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4_rr_pick.sv
// Combinational rotate-priority picker.
//   i_req : request vector
//   i_ptr : highest-priority index this cycle; priority falls off i_ptr, i_ptr+1, ... mod N
//   o_gnt : one-hot grant (all zero when nothing requests)
//   o_idx : index of the granted requester
//   o_any : at least one request present
module axi4_rr_pick
  import axi4_vip_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_best;
  int w_dist;

  // Rank each requester by its rotated distance from i_ptr and keep the
  // closest one; avoids a variable-width rotate and works for any N.
  always_comb begin
    w_best = N;
    w_dist = 0;
    o_idx  = '0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IW'(j);
      end
    end
    o_any = (w_best < N);
    for (int j = 0; j < N; j++) begin
      o_gnt[j] = o_any && (o_idx == IW'(j));
    end
  end

endmodule

// File: rtl/axi4_slave_rresp_arbiter.sv
// Round-robin, burst-granular arbiter sharing one AXI4 R channel between
// NUM_REQ read-burst engines. A granted burst owns the channel until its
// RLAST beat is accepted; the outgoing beat sits in a single register stage.
//   aclk, areset          : clock, synchronous active-high reset
//   req_*                 : per-engine R beats (valid/ready handshake, sliced buses)
//   m_r*                  : registered R channel toward the slave monitor
//   burst_active          : a multi-beat burst currently owns the channel
//   grant_idx             : current or most recent owner
//   burst_count           : completed bursts, wraps at 16 bits
module axi4_slave_rresp_arbiter
  import axi4_vip_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int ID_WIDTH   = 4,
  localparam int IW         = clog2_min1(NUM_REQ)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]     req_id,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*2-1:0]            req_resp,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic                            m_rvalid,
  input  logic                            m_rready,
  output logic [ID_WIDTH-1:0]             m_rid,
  output logic [DATA_WIDTH-1:0]           m_rdata,
  output logic [1:0]                      m_rresp,
  output logic                            m_rlast,
  output logic                            burst_active,
  output logic [IW-1:0]                   grant_idx,
  output logic [15:0]                     burst_count
);

  arb_state_e            r_state, w_state_nxt;
  logic [IW-1:0]         r_rr_ptr, r_grant;
  logic                  r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [15:0]           r_burst_cnt;

  logic [NUM_REQ-1:0]    w_pick_gnt;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_any;
  logic [IW-1:0]         w_sel, w_ptr_nxt;
  logic                  w_can_load, w_sel_vld, w_sel_last, w_load;

  axi4_rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // In LOCKED the owner is pinned; in IDLE the picker result is re-evaluated
  // every cycle until a beat actually loads.
  assign w_can_load = !r_rvalid || m_rready;
  assign w_sel      = (r_state == LOCKED) ? r_grant : w_pick_idx;
  assign w_sel_vld  = (r_state == LOCKED) ? req_valid[w_sel] : w_pick_any;
  assign w_sel_last = req_last[w_sel];
  assign w_load     = !areset && w_can_load && w_sel_vld;
  assign w_ptr_nxt  = (w_sel == IW'(NUM_REQ - 1)) ? '0 : (w_sel + IW'(1));

  // State register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: any accepted beat decides by its RLAST alone.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = w_sel_last ? IDLE : LOCKED;
  end

  // Outputs
  always_comb begin
    req_ready    = '0;
    burst_active = (r_state == LOCKED);
    if (!areset && w_can_load && ((r_state == LOCKED) || w_pick_any))
      req_ready[w_sel] = 1'b1;
  end

  // Output beat register, owner/pointer tracking, completion counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rvalid    <= 1'b0;
      r_rid       <= '0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_rlast     <= 1'b0;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else if (w_load) begin
      r_rvalid <= 1'b1;
      r_rid    <= req_id[w_sel*ID_WIDTH +: ID_WIDTH];
      r_rdata  <= req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
      r_rresp  <= req_resp[w_sel*2 +: 2];
      r_rlast  <= w_sel_last;
      r_grant  <= w_sel;
      if (w_sel_last) begin
        r_rr_ptr    <= w_ptr_nxt;
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
    end else if (m_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign m_rvalid    = r_rvalid;
  assign m_rid       = r_rid;
  assign m_rdata     = r_rdata;
  assign m_rresp     = r_rresp;
  assign m_rlast     = r_rlast;
  assign grant_idx   = r_grant;
  assign burst_count = r_burst_cnt;

endmodule
